// File: rtl/prbs_ber_engine.sv
// PRBS bit-error-rate engine: Fibonacci LFSR generator, self-synchronising checker with
// lock/loss-of-lock FSM, saturating counters and a measurement window. Define ERR_INJECT_EN for error injection.
module prbs_ber_engine #(
   parameter int PRBS_W   = 7,
   parameter int CNT_W    = 32,
   parameter int ERR_W    = 16,
   parameter int LOCK_CNT = 16,
   parameter int LOSS_CNT = 8
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic [PRBS_W-1:0] poly,
   input  logic [PRBS_W-1:0] seed,
   input  logic              tx_en,
   output logic              tx_bit,
   input  logic              rx_bit,
   input  logic              rx_valid,
   input  logic [CNT_W-1:0]  window_len,
   output logic              locked,
   output logic              lock_lost,
   output logic              done,
   output logic [CNT_W-1:0]  bit_count,
   output logic [ERR_W-1:0]  err_count,
   output logic [ERR_W-1:0]  err_total
`ifdef ERR_INJECT_EN
   ,
   input  logic              inject,
   output logic [ERR_W-1:0]  inj_count
`endif
);

   localparam int LOCK_W = $clog2(LOCK_CNT + 1);
   localparam int LOSS_W = $clog2(LOSS_CNT + 1);
   localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CNT);
   localparam logic [LOSS_W-1:0] LOSS_MAX = LOSS_W'(LOSS_CNT);

   typedef enum logic [1:0] {S_IDLE, S_SYNC, S_MEASURE, S_DONE} state_t;

   state_t            state;
   logic [PRBS_W-1:0] gen;
   logic [PRBS_W-1:0] chk;
   logic [LOCK_W-1:0] match_run;
   logic [LOSS_W-1:0] loss_run;
   logic              inj_flip;

   logic              fb;
   logic              pred;
   logic              match;
   logic [CNT_W-1:0]  bit_inc;
   logic [ERR_W-1:0]  err_inc;
   logic [ERR_W-1:0]  tot_inc;
   logic [LOCK_W-1:0] match_run_inc;
   logic [LOSS_W-1:0] loss_run_inc;
   logic              window_hit;

   // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
   always_comb begin
      fb            = ^(gen & poly);
      pred          = ^(chk & poly);
      match         = (rx_bit == pred);
      bit_inc       = (bit_count == '1) ? bit_count : bit_count + CNT_W'(1);
      err_inc       = (err_count == '1) ? err_count : err_count + ERR_W'(1);
      tot_inc       = (err_total == '1) ? err_total : err_total + ERR_W'(1);
      match_run_inc = match_run + LOCK_W'(1);
      loss_run_inc  = loss_run + LOSS_W'(1);
      window_hit    = (window_len != '0) && (bit_inc == window_len);
   end

`ifdef ERR_INJECT_EN
   logic inj_armed;
   assign inj_flip = inj_armed;
`else
   assign inj_flip = 1'b0;
`endif

   // Generator: start reloads the LFSR; an all-zero seed would lock it up, so it becomes 1.
   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         gen    <= PRBS_W'(1);
         tx_bit <= 1'b0;
`ifdef ERR_INJECT_EN
         inj_armed <= 1'b0;
         inj_count <= '0;
`endif
      end else if (start) begin
         gen <= (seed == '0) ? PRBS_W'(1) : seed;
`ifdef ERR_INJECT_EN
         inj_armed <= 1'b0;
         inj_count <= '0;
`endif
      end else begin
         if (tx_en) begin
            gen    <= {gen[PRBS_W-2:0], fb};
            tx_bit <= gen[PRBS_W-1] ^ inj_flip;
         end
`ifdef ERR_INJECT_EN
         if (tx_en && inj_armed) begin
            inj_armed <= 1'b0;
            inj_count <= (inj_count == '1) ? inj_count : inj_count + ERR_W'(1);
         end else if (inject) begin
            inj_armed <= 1'b1;
         end
`endif
      end
   end

   // Checker FSM with registered status outputs.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         chk       <= '0;
         match_run <= '0;
         loss_run  <= '0;
         bit_count <= '0;
         err_count <= '0;
         err_total <= '0;
         locked    <= 1'b0;
         lock_lost <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            state     <= S_SYNC;
            chk       <= '0;
            match_run <= '0;
            loss_run  <= '0;
            bit_count <= '0;
            err_count <= '0;
            err_total <= '0;
            locked    <= 1'b0;
            lock_lost <= 1'b0;
         end else begin
            case (state)
               S_IDLE: ;
               S_SYNC: begin
                  if (stop) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else if (rx_valid) begin
                     chk <= {chk[PRBS_W-2:0], rx_bit};
                     if (match && (chk != '0)) begin
                        if (match_run_inc == LOCK_MAX) begin
                           state     <= S_MEASURE;
                           locked    <= 1'b1;
                           err_count <= '0;
                           match_run <= '0;
                           loss_run  <= '0;
                        end else begin
                           match_run <= match_run_inc;
                        end
                     end else begin
                        match_run <= '0;
                     end
                  end
               end
               S_MEASURE: begin
                  if (stop) begin
                     state  <= S_DONE;
                     done   <= 1'b1;
                     locked <= 1'b0;
                  end else if (rx_valid) begin
                     chk       <= {chk[PRBS_W-2:0], pred};
                     bit_count <= bit_inc;
                     if (!match) begin
                        err_count <= err_inc;
                        err_total <= tot_inc;
                        loss_run  <= loss_run_inc;
                     end else begin
                        loss_run <= '0;
                     end
                     // Window completion takes priority over a simultaneous loss of lock.
                     if (window_hit) begin
                        state  <= S_DONE;
                        done   <= 1'b1;
                        locked <= 1'b0;
                     end else if (!match && (loss_run_inc == LOSS_MAX)) begin
                        state     <= S_SYNC;
                        locked    <= 1'b0;
                        lock_lost <= 1'b1;
                        chk       <= '0;
                        loss_run  <= '0;
                        match_run <= '0;
                     end
                  end
               end
               S_DONE: ;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prbs_ber_engine.sv
// Self-checking bench for prbs_ber_engine in PRBS7 loopback; tx_bit is scored against a reference
// LFSR through an expected-value queue, counters against constants derived from the stimulus.
module tb_prbs_ber_engine;

   localparam int PRBS_W = 7;
   localparam int CNT_W  = 32;
   localparam int ERR_W  = 4;

   logic              clock = 1'b0;
   logic              rst_n, start, stop, tx_en, rx_valid, rx_flip, inject;
   logic [PRBS_W-1:0] poly, seed;
   logic [CNT_W-1:0]  window_len;
   logic              tx_bit, rx_bit, locked, lock_lost, done;
   logic [CNT_W-1:0]  bit_count;
   logic [ERR_W-1:0]  err_count, err_total;
`ifdef ERR_INJECT_EN
   logic [ERR_W-1:0]  inj_count;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic [PRBS_W-1:0] m_gen;
   logic              m_tx;
   logic              m_armed;
   logic              exp_q[$];

   assign rx_bit = tx_bit ^ rx_flip;

   always #5 clock = ~clock;

   prbs_ber_engine #(.PRBS_W(PRBS_W), .CNT_W(CNT_W), .ERR_W(ERR_W), .LOCK_CNT(16), .LOSS_CNT(8)) dut (
      .clock(clock), .rst_n(rst_n), .start(start), .stop(stop), .poly(poly), .seed(seed),
      .tx_en(tx_en), .tx_bit(tx_bit), .rx_bit(rx_bit), .rx_valid(rx_valid), .window_len(window_len),
      .locked(locked), .lock_lost(lock_lost), .done(done), .bit_count(bit_count),
      .err_count(err_count), .err_total(err_total)
`ifdef ERR_INJECT_EN
      , .inject(inject), .inj_count(inj_count)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_gen   = PRBS_W'(1);
      m_tx    = 1'b0;
      m_armed = 1'b0;
      exp_q.delete();
   endtask

   // One clock: advance the reference generator, queue its tx_bit, then score the DUT output.
   task automatic step();
      if (start) begin
         m_gen   = (seed == '0) ? PRBS_W'(1) : seed;
         m_armed = 1'b0;
      end else begin
         if (tx_en) begin
            m_tx  = m_gen[PRBS_W-1] ^ m_armed;
            m_gen = {m_gen[PRBS_W-2:0], ^(m_gen & poly)};
         end
`ifdef ERR_INJECT_EN
         if (tx_en && m_armed) m_armed = 1'b0;
         else if (inject) m_armed = 1'b1;
`endif
      end
      exp_q.push_back(m_tx);
      @(posedge clock);
      #1;
      check("tx_bit", tx_bit, exp_q.pop_front());
   endtask

   task automatic wait_lock(input int budget);
      int n = 0;
      while (!locked && n < budget) begin
         step();
         n++;
      end
      check("lock_within_budget", locked, 1'b1);
   endtask

   // Drive n measured bits, inverting every period-th one (period 0 = clean).
   task automatic run_bits(input int n, input int period, output logic saw_done, output logic saw_unlock);
      saw_done   = 1'b0;
      saw_unlock = 1'b0;
      for (int k = 1; k <= n; k++) begin
         rx_flip = (period != 0) && (k % period == 0);
         step();
         if (k < n && done) saw_done = 1'b1;
         if (k < n && !locked) saw_unlock = 1'b1;
      end
      rx_flip = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic sd, su;
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; tx_en = 1'b1; rx_valid = 1'b1; rx_flip = 1'b0;
      inject = 1'b0; poly = 7'h60; seed = 7'h01; window_len = 1000;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check("rst_tx_bit", tx_bit, 0);
      check("rst_locked", locked, 0);
      check("rst_done", done, 0);
      check("rst_bit_count", bit_count, 0);
      check("rst_err_total", err_total, 0);
`ifdef ERR_INJECT_EN
      check("rst_inj_count", inj_count, 0);
`endif
      rst_n = 1'b1;

      // Clean loopback, 1000-bit window; lock expected within 7+16+2 cycles of start.
      pulse_start();
      wait_lock(25);
      run_bits(1000, 0, sd, su);
      check("t1_no_early_done", sd, 0);
      check("t1_stayed_locked", su, 0);
      check("t1_done", done, 1);
      check("t1_bit_count", bit_count, 1000);
      check("t1_err_count", err_count, 0);
      check("t1_err_total", err_total, 0);
      check("t1_lock_lost", lock_lost, 0);
      step();
      check("t1_done_one_cycle", done, 0);

      // Every 100th bit inverted: 10 errors in the window.
      pulse_start();
      wait_lock(64);
      run_bits(1000, 100, sd, su);
      check("t2_stayed_locked", su, 0);
      check("t2_done", done, 1);
      check("t2_err_count", err_count, 10);
      check("t2_err_total", err_total, 10);

      // Eight consecutive inverted bits drop lock; the checker re-locks on clean data.
      window_len = 0;
      pulse_start();
      wait_lock(64);
      run_bits(20, 0, sd, su);
      run_bits(8, 1, sd, su);
      check("t3_locked_until_8th", su, 0);
      check("t3_unlocked", locked, 0);
      check("t3_lock_lost", lock_lost, 1);
      check("t3_err_total_at_loss", err_total, 8);
      wait_lock(64);
      check("t3_err_count_restart", err_count, 0);
      check("t3_err_total_kept", err_total, 8);
      check("t3_lock_lost_sticky", lock_lost, 1);
      check("t3_bit_count_kept", bit_count, 28);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("t3_stop_done", done, 1);

      // Every 3rd bit inverted, open window, stop after 200 bits: 66 errors saturate at 15.
      pulse_start();
      wait_lock(64);
      run_bits(200, 3, sd, su);
      check("t4_no_done_open_window", sd, 0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("t4_done", done, 1);
      check("t4_err_count_sat", err_count, 15);
      check("t4_err_total_sat", err_total, 15);
      check("t4_bit_count", bit_count, 200);
      repeat (3) step();
      check("t4_hold_done_low", done, 0);
      check("t4_hold_bit_count", bit_count, 200);
      check("t4_hold_err_total", err_total, 15);
      pulse_start();
      check("t4_start_bit_count", bit_count, 0);
      check("t4_start_err_count", err_count, 0);
      check("t4_start_err_total", err_total, 0);

      // Asynchronous reset mid-measurement, then simultaneous start and stop.
      wait_lock(64);
      run_bits(10, 0, sd, su);
      rst_n = 1'b0;
      #1;
      check("t5_async_locked", locked, 0);
      check("t5_async_bit_count", bit_count, 0);
      check("t5_async_tx_bit", tx_bit, 0);
      model_reset();
      @(posedge clock);
      #1;
      check("t5_no_done_in_reset", done, 0);
      check("t5_err_total", err_total, 0);
      rst_n = 1'b1;
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      check("t5_start_wins_no_done", done, 0);
      step();
      check("t5_still_no_done", done, 0);
      wait_lock(64);

`ifdef ERR_INJECT_EN
      // Three accepted injections; the second cycle of the last pulse arrives while armed.
      window_len = 500;
      pulse_start();
      wait_lock(64);
      for (int k = 1; k <= 500; k++) begin
         inject = (k == 50) || (k == 150) || (k == 250) || (k == 251);
         step();
      end
      inject = 1'b0;
      check("t6_done", done, 1);
      check("t6_inj_count", inj_count, 3);
      check("t6_err_count", err_count, 3);
      check("t6_err_total", err_total, 3);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
